// File: rtl/quat_sync_sink.sv
// Clocked sink for a 1-of-4 NCL quaternary link: synchronizes the rails, acks wavefronts,
// decodes them and buffers the values into a valid/ready stream. QUAT_SUM_EN adds a sum port.
module quat_sync_sink #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PW         = $clog2(DEPTH),
  localparam int unsigned LW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          init,
  input  logic [3:0]    quatin,
  output logic          quatincomp,
  output logic [1:0]    dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [LW-1:0] level,
  output logic          err_multi
`ifdef QUAT_SUM_EN
  ,
  output logic [7:0]    sum
`endif
);

  typedef enum logic [0:0] {StWaitData, StWaitNull} state_e;

  localparam logic [LW-1:0] FullLvl = LW'(DEPTH);

  // Synchronizer: stage 0 samples the async rails, the last stage is "q"
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  q, qp_q, qp_d;

  state_e          state_q, state_d;
  logic            quatincomp_q, quatincomp_d;
  logic            err_q, err_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d, mem_cnt;
  logic [1:0]      dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
`ifdef QUAT_SUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  logic       data_stable, null_stable, one_hot;
  logic [1:0] value;
  logic       push, pop, full, load;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], quatin};
    q      = sync_q[SYNC_STAGES-1];
    qp_d   = q;
  end

  always_comb begin
    data_stable = (q != 4'd0) && (q == qp_q);
    null_stable = (q == 4'd0) && (qp_q == 4'd0);
    one_hot     = (q != 4'd0) && ((q & (q - 4'd1)) == 4'd0);
    value       = 2'd0;
    unique case (q)
      4'b0001: value = 2'd0;
      4'b0010: value = 2'd1;
      4'b0100: value = 2'd2;
      4'b1000: value = 2'd3;
      default: value = 2'd0;
    endcase
  end

  assign pop  = dout_valid_q && dout_ready;
  assign full = (level_q == FullLvl);

  // Handshake FSM; a full FIFO withholds the ack, a same-cycle pop frees the slot
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      StWaitData: begin
        if (data_stable) begin
          if (one_hot) begin
            if (!full || pop) begin
              push    = 1'b1;
              state_d = StWaitNull;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StWaitNull;
          end
        end
      end
      StWaitNull: begin
        if (null_stable) begin
          state_d = StWaitData;
        end
      end
      default: state_d = StWaitData;
    endcase
    quatincomp_d = (state_d == StWaitNull);
  end

  // FIFO memory plus a registered head; level counts both
  always_comb begin
    mem_cnt = level_q - LW'(dout_valid_q);
    load    = (mem_cnt != '0) && (!dout_valid_q || pop);

    mem_d = mem_q;
    if (push) begin
      mem_d[wptr_q] = value;
    end
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = load ? rptr_q + PW'(1) : rptr_q;
    level_d = level_q + LW'(push) - LW'(pop);

    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (load) begin
      dout_d       = mem_q[rptr_q];
      dout_valid_d = 1'b1;
    end else if (pop) begin
      dout_valid_d = 1'b0;
    end
  end

`ifdef QUAT_SUM_EN
  always_comb begin
    sum_d = push ? sum_q + {6'd0, value} : sum_q;
  end
`endif

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      sync_q       <= '0;
      qp_q         <= 4'd0;
      state_q      <= StWaitData;
      quatincomp_q <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'd0;
      end
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      dout_q       <= 2'd0;
      dout_valid_q <= 1'b0;
`ifdef QUAT_SUM_EN
      sum_q        <= 8'd0;
`endif
    end else begin
      sync_q       <= sync_d;
      qp_q         <= qp_d;
      state_q      <= state_d;
      quatincomp_q <= quatincomp_d;
      err_q        <= err_d;
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef QUAT_SUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign quatincomp = quatincomp_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign level      = level_q;
  assign err_multi  = err_q;
`ifdef QUAT_SUM_EN
  assign sum        = sum_q;
`endif

endmodule

// File: tb/tb_quat_sync_sink.sv
// Randomized bench for quat_sync_sink with a queue-based reference model checked every cycle.
module tb_quat_sync_sink;
  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          init = 1'b1;
  logic [3:0]    quatin = 4'd0;
  logic          dout_ready = 1'b0;
  logic          quatincomp;
  logic [1:0]    dout;
  logic          dout_valid;
  logic [LW-1:0] level;
  logic          err_multi;
`ifdef QUAT_SUM_EN
  logic [7:0]    sum;
`endif

  always #5 clk = ~clk;

  quat_sync_sink #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .init       (init),
    .quatin     (quatin),
    .quatincomp (quatincomp),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level)
    ,.err_multi (err_multi)
`ifdef QUAT_SUM_EN
    ,.sum       (sum)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a token becomes visible on dout one edge after its push, and never
  // earlier than the edge that pops its predecessor.
  typedef struct {int val; int vis;} tok_t;
  tok_t       mq[$];
  int         m_e, m_sum, m_last;
  bit         m_ack, m_err;
  logic [3:0] m_sync [0:SS];

  initial begin
    logic [3:0] q, qp;
    bit pop, vnow;
    int sz0, v;
    tok_t t;
    forever begin
      @(posedge clk or posedge init);
      if (init) begin
        mq.delete();
        m_e = 0; m_sum = 0; m_last = 0; m_ack = 0; m_err = 0;
        for (int i = 0; i <= SS; i++) m_sync[i] = 4'd0;
      end else begin
        q    = m_sync[SS-1];
        qp   = m_sync[SS];
        vnow = (mq.size() > 0) && (mq[0].vis <= m_e);
        m_e++;
        pop  = vnow && dout_ready;
        sz0  = mq.size();
        if (pop) begin
          void'(mq.pop_front());
          if (mq.size() > 0 && mq[0].vis < m_e) begin
            t = mq[0]; t.vis = m_e; mq[0] = t;
          end
        end
        if (!m_ack) begin
          if (q != 4'd0 && q == qp) begin
            if ($countones(q) == 1) begin
              if (sz0 < DEPTH || pop) begin
                v = 0;
                for (int k = 0; k < 4; k++) if (q[k]) v = k;
                t.val = v; t.vis = m_e + 1;
                mq.push_back(t);
                m_sum = (m_sum + v) % 256;
                m_ack = 1;
              end
            end else begin
              m_err = 1;
              m_ack = 1;
            end
          end
        end else if (q == 4'd0 && qp == 4'd0) begin
          m_ack = 0;
        end
        for (int i = SS; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = quatin;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (!init) begin
        ev = (mq.size() > 0) && (mq[0].vis <= m_e);
        check("quatincomp", quatincomp, m_ack);
        check("level", level, mq.size());
        check("dout_valid", dout_valid, ev);
        check("err_multi", err_multi, m_err);
        if (ev) begin
          check("dout", dout, mq[0].val);
          m_last = mq[0].val;
        end else begin
          check("dout_hold", dout, m_last);
        end
`ifdef QUAT_SUM_EN
        check("sum", sum, m_sum);
`endif
      end
    end
  end

  int got[$];
  initial forever begin
    @(posedge clk);
    if (!init && dout_valid && dout_ready) got.push_back(dout);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_ready) dout_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_comp(input bit v, input int budget, input string name);
    for (int i = 0; i < budget && quatincomp !== v; i++) tick(1);
    n_tests++;
    if (quatincomp !== v) begin
      n_fail++;
      $display("FAIL %s: quatincomp got %0b required %0b (timeout)", name, quatincomp, v);
    end
  endtask

  task automatic send(input int v);
    wait_comp(1'b0, 300, "send_idle");
    tick($urandom_range(0, 2));
    quatin = 4'(1 << v);
    wait_comp(1'b1, 300, "send_ack");
    tick($urandom_range(0, 2));
    quatin = 4'd0;
    wait_comp(1'b0, 300, "send_null");
  endtask

  task automatic do_reset();
    init = 1'b1;
    tick(2);
    init = 1'b0;
  endtask

  int ring_v[6] = '{0, 1, 2, 3, 3, 2};

  initial begin
    logic [3:0] pat;
    int kind;
    // Reset values
    tick(3);
    #1;
    check("rst_quatincomp", quatincomp, 0);
    check("rst_level", level, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_err", err_multi, 0);
    @(negedge clk);
    init = 1'b0;

    // Single token, held
    dout_ready = 1'b0;
    send(2);
    tick(4);
    check("single_dout", dout, 2);
    check("single_valid", dout_valid, 1);
    check("single_level", level, 1);

    // Ring stream
    do_reset();
    dout_ready = 1'b1;
    got.delete();
    foreach (ring_v[i]) send(ring_v[i]);
    tick(6);
    check("ring_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("ring_val", got[i], ring_v[i]);
`ifdef QUAT_SUM_EN
    check("ring_sum", sum, 11);
`endif

    // Backpressure
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(i);
    tick(3);
    check("bp_level_full", level, 4);
    quatin = 4'b0010;
    tick(10);
    check("bp_stall_comp", quatincomp, 0);
    check("bp_stall_level", level, 4);
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    wait_comp(1'b1, 20, "bp_accept");
    check("bp_level_after", level, 4);
    quatin = 4'd0;
    wait_comp(1'b0, 20, "bp_null");

    // Multi-rail
    dout_ready = 1'b1;
    tick(12);
    dout_ready = 1'b0;
    check("drain_level", level, 0);
    quatin = 4'b0011;
    wait_comp(1'b1, 20, "multi_ack");
    check("multi_err", err_multi, 1);
    check("multi_level", level, 0);
    quatin = 4'd0;
    wait_comp(1'b0, 20, "multi_null");
    send(1);
    tick(4);
    check("multi_next_level", level, 1);
    check("multi_next_dout", dout, 1);

    // Glitch filter
    quatin = 4'b1000;
    tick(1);
    quatin = 4'd0;
    tick(8);
    check("glitch_comp", quatincomp, 0);
    check("glitch_level", level, 1);

    // Reset mid-handshake
    send(2);
    quatin = 4'b0100;
    wait_comp(1'b1, 20, "mid_ack");
    check("mid_level", level, 3);
    #3;
    init = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_valid", dout_valid, 0);
    check("arst_comp", quatincomp, 0);
    check("arst_err", err_multi, 0);
    @(negedge clk);
    init = 1'b0;
    wait_comp(1'b1, 20, "rel_ack");
    tick(3);
    check("rel_level", level, 1);
    check("rel_dout", dout, 2);
    quatin = 4'd0;
    wait_comp(1'b0, 20, "rel_null");

    // Randomized traffic
    rnd_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 99);
      if (kind < 8) begin
        wait_comp(1'b0, 300, "rnd_idle");
        do pat = 4'($urandom_range(1, 15)); while ($countones(pat) < 1);
        quatin = pat;
        tick(1);
        quatin = 4'd0;
        tick($urandom_range(3, 6));
      end else if (kind < 15) begin
        wait_comp(1'b0, 300, "rnd_idle");
        do pat = 4'($urandom_range(3, 15)); while ($countones(pat) < 2);
        quatin = pat;
        wait_comp(1'b1, 300, "rnd_multi_ack");
        quatin = 4'd0;
        wait_comp(1'b0, 300, "rnd_multi_null");
      end else begin
        wait_comp(1'b0, 300, "rnd_idle");
        tick($urandom_range(0, 3));
        quatin = 4'(1 << $urandom_range(0, 3));
        wait_comp(1'b1, 300, "rnd_ack");
        // Partial patterns while awaiting NULL must be ignored
        repeat ($urandom_range(0, 3)) begin
          quatin = 4'($urandom_range(1, 15));
          tick(1);
        end
        quatin = 4'd0;
        wait_comp(1'b0, 300, "rnd_null");
      end
    end
    rnd_ready = 1'b0;
    dout_ready = 1'b1;
    tick(20);
    check("final_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
